// File: rtl/me_result_writer_if.sv
// Result-memory write port: valid/ready handshake carrying a byte address and one packed result word.
interface me_result_writer_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/me_result_writer.sv
// Captures motion-estimation best-match results on data_valid rising edges, queues them in a
// small FIFO and writes them to consecutive result-memory words under frame-level control.
module me_result_writer #(
  parameter int unsigned SAD_BIT_WIDTH = 14,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter logic [15:0] NUM_BLOCKS    = 16'd396,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [SAD_BIT_WIDTH-1:0] MSAD,
  input  logic [4:0]               MSAD_column,
  input  logic [4:0]               MSAD_row,
  input  logic                     data_valid,
  me_result_writer_if.master       wr,
  output logic [15:0]              blocks_written,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e        state_q, state_d;
  logic          dv_q;
  logic [15:0]   cap_cnt_q, cap_cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [15:0]   blk_q, blk_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic          rise, start_ok, push, pop, full, push_ok, valid;
  logic [13:0]   msad_ext;
  logic [31:0]   word;

  always_comb begin
    msad_ext                    = '0;
    msad_ext[SAD_BIT_WIDTH-1:0] = MSAD;
    word     = {cap_cnt_q[7:0], MSAD_row, MSAD_column, msad_ext};
    rise     = data_valid & ~dv_q;
    valid    = (count_q != '0) && ((state_q == S_RUN) || (state_q == S_DRAIN));
    full     = (count_q == DEPTH_C);
    pop      = valid & wr.wr_ready;
    push     = rise && (state_q == S_RUN);
    // A full FIFO still accepts the push when the head leaves in the same cycle.
    push_ok  = push && (!full || pop);
    start_ok = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  end

  always_comb begin
    state_d   = state_q;
    cap_cnt_d = cap_cnt_q;
    addr_d    = addr_q;
    blk_d     = blk_q;
    ovf_d     = ovf_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_d   = S_RUN;
          cap_cnt_d = '0;
          blk_d     = '0;
          ovf_d     = 1'b0;
          addr_d    = BASE_ADDR;
        end
      end
      S_RUN: begin
        if (push) begin
          cap_cnt_d = cap_cnt_q + 16'd1;
          if (!push_ok) ovf_d = 1'b1;
          if (cap_cnt_q + 16'd1 == NUM_BLOCKS) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (count_q == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      addr_d   = addr_q + 32'd4;
      blk_d    = (blk_q == '1) ? blk_q : blk_q + 16'd1;
    end
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      dv_q      <= 1'b0;
      cap_cnt_q <= '0;
      addr_q    <= BASE_ADDR;
      blk_q     <= '0;
      ovf_q     <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      dv_q      <= data_valid;
      cap_cnt_q <= cap_cnt_d;
      addr_q    <= addr_d;
      blk_q     <= blk_d;
      ovf_q     <= ovf_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= word;
    end
  end

  always_comb begin
    wr.wr_valid    = valid;
    wr.wr_data     = mem_q[rd_ptr_q];
    wr.wr_addr     = addr_q;
    blocks_written = blk_q;
    busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
    done           = (state_q == S_DONE);
    overflow       = ovf_q;
  end

endmodule

// File: tb/tb_me_result_writer.sv
// Bench for me_result_writer: queue-based frame model compared every cycle, directed scenarios
// with literal expectations, then randomized frames.
module tb_me_result_writer;
  localparam int unsigned SAD_W = 14;
  localparam int unsigned DEPTH = 4;
  localparam logic [15:0] NB    = 16'd5;
  localparam logic [31:0] BASE  = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        data_valid = 1'b0;
  logic        ready = 1'b0;
  logic [13:0] msad = '0;
  logic [4:0]  row = '0, col = '0;
  logic [15:0] blocks_written;
  logic        busy, done, overflow;

  me_result_writer_if wif();
  assign wif.wr_ready = ready;

  me_result_writer #(
    .SAD_BIT_WIDTH(SAD_W),
    .FIFO_DEPTH   (DEPTH),
    .NUM_BLOCKS   (NB),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .MSAD          (msad),
    .MSAD_column   (col),
    .MSAD_row      (row),
    .data_valid    (data_valid),
    .wr            (wif),
    .blocks_written(blocks_written),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: phase 0 idle, 1 run, 2 drain, 3 done; pending results held in a queue.
  int          m_phase;
  int unsigned m_cnt;
  logic [31:0] m_addr;
  int unsigned m_written;
  logic        m_ovf, m_prev_dv;
  logic [31:0] mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_phase = 0; m_cnt = 0; m_addr = BASE; m_written = 0;
    m_ovf = 1'b0; m_prev_dv = 1'b0; mq.delete();
  endfunction

  function automatic bit m_valid();
    return ((m_phase == 1) || (m_phase == 2)) && (mq.size() > 0);
  endfunction

  function automatic void m_step();
    bit rise, pop, push;
    logic [31:0] w;
    logic [31:0] c;
    if (!rst) begin m_reset(); return; end
    rise = data_valid && !m_prev_dv;
    m_prev_dv = data_valid;
    pop  = m_valid() && ready;
    push = 1'b0;
    w    = '0;
    case (m_phase)
      0, 3: if (start_i) begin
        m_phase = 1; m_cnt = 0; m_written = 0; m_ovf = 1'b0; m_addr = BASE;
      end
      1: if (rise) begin
        c = m_cnt;
        w = {c[7:0], row, col, msad};
        if (mq.size() < DEPTH || pop) push = 1'b1;
        else m_ovf = 1'b1;
        m_cnt++;
        if (m_cnt == NB) m_phase = 2;
      end
      2: if (mq.size() == 0) m_phase = 3;
      default: ;
    endcase
    if (pop) begin
      void'(mq.pop_front());
      m_addr += 32'd4;
      if (m_written < 65535) m_written++;
    end
    if (push) mq.push_back(w);
  endfunction

  task automatic compare();
    chk("wr_valid", {31'd0, wif.wr_valid}, {31'd0, m_valid()});
    if (m_valid()) chk("wr_data", wif.wr_data, mq[0]);
    chk("wr_addr", wif.wr_addr, m_addr);
    chk("blocks_written", {16'd0, blocks_written}, m_written);
    chk("busy", {31'd0, busy}, {31'd0, (m_phase == 1) || (m_phase == 2)});
    chk("done", {31'd0, done}, {31'd0, m_phase == 3});
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
  endtask

  task automatic tick();
    m_step();
    @(negedge clk);
    compare();
  endtask

  task automatic pulse_start();
    start_i = 1'b1; tick(); start_i = 1'b0;
  endtask

  task automatic rise_rand();
    msad = 14'($urandom); row = 5'($urandom); col = 5'($urandom);
    data_valid = 1'b1; tick(); data_valid = 1'b0; tick();
  endtask

  task automatic run_until_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) break;
      tick();
    end
    chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    compare();
    chk("reset_addr", wif.wr_addr, 32'hFFFF_FFF8);
    chk("reset_done", {31'd0, done}, 32'd0);
    rst = 1'b1;
    tick();

    // Basic write with literal words and one-cycle latency
    ready = 1'b1;
    pulse_start();
    msad = 14'h0123; row = 5'd3; col = 5'd17; data_valid = 1'b1; tick();
    chk("basic_valid0", {31'd0, wif.wr_valid}, 32'd1);
    chk("basic_data0", wif.wr_data, 32'h001C_4123);
    chk("basic_addr0", wif.wr_addr, 32'hFFFF_FFF8);
    data_valid = 1'b0; tick();
    msad = 14'h3FFF; row = 5'd0; col = 5'd31; data_valid = 1'b1; tick();
    chk("basic_data1", wif.wr_data, 32'h0107_FFFF);
    chk("basic_addr1", wif.wr_addr, 32'hFFFF_FFFC);
    data_valid = 1'b0; tick();
    repeat (3) rise_rand();
    run_until_done(50);
    chk("basic_blocks", {16'd0, blocks_written}, 32'd5);
    chk("basic_final_addr", wif.wr_addr, 32'h0000_000C);

    // Backpressure with overflow: five rises into four entries
    ready = 1'b0;
    pulse_start();
    repeat (5) rise_rand();
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_none_written", {16'd0, blocks_written}, 32'd0);
    repeat (10) tick();
    chk("bp_held_addr", wif.wr_addr, BASE);
    ready = 1'b1;
    run_until_done(50);
    chk("ovf_blocks", {16'd0, blocks_written}, 32'd4);

    // Full FIFO with simultaneous push and pop
    ready = 1'b0;
    pulse_start();
    repeat (4) rise_rand();
    msad = 14'h0AAA; row = 5'd9; col = 5'd4; data_valid = 1'b1; ready = 1'b1; tick();
    ready = 1'b0; data_valid = 1'b0; tick();
    chk("pushpop_no_ovf", {31'd0, overflow}, 32'd0);
    ready = 1'b1;
    run_until_done(50);
    chk("pushpop_blocks", {16'd0, blocks_written}, 32'd5);

    // Gating: held data_valid, start during RUN, rise in DONE
    pulse_start();
    data_valid = 1'b1;
    repeat (8) tick();
    data_valid = 1'b0; tick();
    chk("held_dv_one", {16'd0, blocks_written}, 32'd1);
    pulse_start();
    chk("start_in_run_busy", {31'd0, busy}, 32'd1);
    chk("start_in_run_blocks", {16'd0, blocks_written}, 32'd1);
    repeat (4) rise_rand();
    run_until_done(50);
    rise_rand();
    chk("done_rise_ignored", {31'd0, wif.wr_valid}, 32'd0);
    chk("done_blocks", {16'd0, blocks_written}, 32'd5);

    // Async reset during DRAIN with two entries queued
    ready = 1'b1;
    pulse_start();
    repeat (3) rise_rand();
    ready = 1'b0;
    repeat (2) rise_rand();
    chk("drain_busy", {31'd0, busy}, 32'd1);
    chk("drain_valid", {31'd0, wif.wr_valid}, 32'd1);
    rst = 1'b0;
    #1;
    m_reset();
    compare();
    chk("rst_valid", {31'd0, wif.wr_valid}, 32'd0);
    chk("rst_addr", wif.wr_addr, 32'hFFFF_FFF8);
    tick();
    rst = 1'b1; ready = 1'b1;
    tick();
    pulse_start();
    msad = 14'h0001; row = 5'd1; col = 5'd1; data_valid = 1'b1; tick();
    chk("after_rst_addr", wif.wr_addr, 32'hFFFF_FFF8);
    chk("after_rst_data", wif.wr_data, 32'h0008_4001);
    data_valid = 1'b0; tick();
    repeat (4) rise_rand();
    run_until_done(50);

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      pulse_start();
      for (int c = 0; c < 400; c++) begin
        data_valid = ($urandom_range(0, 1) == 1);
        ready      = ($urandom_range(0, 3) != 0);
        start_i    = ($urandom_range(0, 15) == 0);
        msad = 14'($urandom); row = 5'($urandom); col = 5'($urandom);
        tick();
        if (m_phase == 3) break;
      end
      start_i = 1'b0; data_valid = 1'b0; ready = 1'b1;
      run_until_done(50);
      for (int c = 0; c < 6; c++) begin
        data_valid = ($urandom_range(0, 1) == 1);
        tick();
      end
      data_valid = 1'b0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/me_result_writer.md
Name: me_result_writer

Overview:
- Downstream consumer of the motion-estimation core.
- Captures each per-block best-match result (MSAD, MSAD_row, MSAD_column) on the rising edge of data_valid and packs it into a 32-bit word.
- Buffers results in a small FIFO and writes them to result memory over a valid/ready write port at consecutive word addresses.
- Frame-level control: start pulse, block counter, drain and done, sticky overflow flag.

Parameters:
- SAD_BIT_WIDTH, 14, width of MSAD input; must be ≤14, zero-extended to 14 in the packed word.
- FIFO_DEPTH, 4, result FIFO entries; power of 2, ≥2.
- NUM_BLOCKS, 16'd396, blocks per frame (1..65535).
- BASE_ADDR, 32'h0000_0000, byte address of the first result word; word-aligned.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse that begins a frame.
- MSAD  in  SAD_BIT_WIDTH  best SAD from the ME core.
- MSAD_column  in  5  best-match column.
- MSAD_row  in  5  best-match row.
- data_valid  in  1  ME result-valid; only its rising edge is used.
- wr_valid  out  1  write request.
- wr_ready  in  1  memory accepts the write this cycle.
- wr_addr  out  32  byte address of the write.
- wr_data  out  32  packed result.
- blocks_written  out  16  count of completed writes this frame.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- overflow  out  1  sticky: a result was dropped because the FIFO was full.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; FIFO is emptied.
  - wr_valid=0, wr_addr=BASE_ADDR, wr_data=0, blocks_written=0, busy=0, done=0, overflow=0.
  - Capture counter = 0; data_valid edge register = 0.
  - Reset mid-frame discards all FIFO contents.
- Edge detect: dv_d registers data_valid every cycle in every state; rise = data_valid & ~dv_d.
- States:
  - IDLE: start_i → RUN.
  - RUN: clears nothing further; rise events are captured.
  - RUN → DRAIN on the cycle the capture counter reaches NUM_BLOCKS.
  - DRAIN → DONE when the FIFO is empty and no transfer is pending.
  - DONE: start_i → RUN.
  - start_i is ignored in RUN and DRAIN.
- On a start_i that is accepted: capture counter, blocks_written and overflow clear, and wr_addr ← BASE_ADDR.
- Capture (RUN only):
  - On rise, push {cap_cnt[7:0], MSAD_row, MSAD_column, zero-extended MSAD} (bits 31:24, 23:19, 18:14, 13:0).
  - Capture counter increments on every rise in RUN, including dropped results.
  - Rise events in IDLE, DRAIN or DONE are ignored and not counted.
- Full FIFO:
  - Push when full with no pop in the same cycle: the result is dropped and overflow is set to 1.
  - Push and pop in the same cycle when full: the push is accepted.
- Write port:
  - wr_valid = FIFO non-empty, in RUN or DRAIN; wr_data = FIFO head.
  - wr_data and wr_addr are held stable while wr_valid=1 and wr_ready=0.
  - Transfer on wr_valid & wr_ready: pop, wr_addr += 4, blocks_written += 1.
  - wr_ready while wr_valid=0 has no effect.
- Latency: a rise in cycle t with the FIFO empty gives wr_valid=1 in cycle t+1. Throughput is 1 result per cycle.
- Wrap-around:
  - The 8-bit block index field wraps 255→0.
  - wr_addr wraps modulo 2^32.
  - blocks_written saturates at 16'hFFFF.
- The FIFO empties naturally in DONE; done deasserts on the cycle after an accepted start_i.

Test Plan:
- Basic write:
  - Reset, NUM_BLOCKS=2, start_i, wr_ready=1.
  - data_valid rises with MSAD=14'h0123, row=5'd3, col=5'd17; then MSAD=14'h3FFF, row=0, col=31.
  - Expect wr_data=32'h001C_4123 at addr 0, then 32'h0107_FFFF at addr 4.
  - Expect each wr_valid one cycle after its rise, blocks_written=2, done=1.
- Backpressure:
  - wr_ready=0 for 10 cycles while 3 rises occur.
  - Expect wr_valid held with stable data/addr and no loss.
  - Release wr_ready: 3 consecutive transfers, addresses +4 each.
- Overflow:
  - wr_ready=0, 5 rises with FIFO_DEPTH=4.
  - Expect overflow=1 and only 4 words written (indices 0–3).
  - Capture counter reaches 5, so NUM_BLOCKS=5 still reaches DONE.
- Full-FIFO push/pop:
  - FIFO full; wr_ready=1 in the same cycle as a rise.
  - Expect push accepted and overflow stays 0.
- Gating:
  - data_valid held high across many cycles → only one capture.
  - Rise in IDLE or DONE → no write.
  - start_i during RUN → ignored, counters unchanged.
- Async reset mid-DRAIN with 2 entries queued:
  - Expect immediate wr_valid=0, state IDLE, outputs at reset values.
  - Next frame starts at BASE_ADDR with index 0.
